capture_bram: RTL and testbench

CAPTURE_BRAM -- requirements
Module: capture_bram

---
 rtl/la_pkg.sv | 12 +
 rtl/capture_bram_if.sv | 33 +++
 rtl/bram_sdp.sv | 29 ++
 rtl/capture_bram.sv | 101 ++++++++++
 tb/tb_capture_bram.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyser definitions: capture state encodings used by the
// capture controller and visible on its state output.
package la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

endpackage

// File: rtl/capture_bram_if.sv
// Control, sample and readback bundle between a capture_bram and its host.
interface capture_bram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  // Strobe semantics (no backpressure): SAMPLE_EN accepts one sample per
  // cycle while high; RD_EN returns data_out one cycle later, which then
  // holds until the next RD_EN.
  logic              ARM;
  logic              ABORT;
  logic              SAMPLE_EN;
  logic [DATA_W-1:0] sample_in;
  logic              TRIG;
  logic [ADDR_W-1:0] post_count;
  logic              RD_EN;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        state;
  logic              DONE;
  logic              wrapped;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;

  modport master (
    output ARM, ABORT, SAMPLE_EN, sample_in, TRIG, post_count, RD_EN, rd_addr,
    input  data_out, state, DONE, wrapped, trig_addr, start_addr
  );

  modport slave (
    input  ARM, ABORT, SAMPLE_EN, sample_in, TRIG, post_count, RD_EN, rd_addr,
    output data_out, state, DONE, wrapped, trig_addr, start_addr
  );
endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Contents are not cleared by reset; only the read register is.
module bram_sdp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/capture_bram.sv
// Triggered sample capture into a circular block RAM with post-trigger count
// and readback relative to the oldest valid sample.
module capture_bram
  import la_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input logic           CLK,
  input logic           RST,
  capture_bram_if.slave bus
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ARMED = ST_ARMED;
  localparam logic [1:0] S_TRIG  = ST_TRIGGERED;
  localparam logic [1:0] S_DONE  = ST_DONE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wrapped_q;
  logic [ADDR_W-1:0] post_lat;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] trig_q;
  logic [ADDR_W-1:0] start_q;

  logic              capturing;
  logic              wr_en;
  logic              is_trig;
  logic              finish;
  logic              at_last;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [ADDR_W-1:0] start_nxt;
  logic [ADDR_W-1:0] rd_phys;

  always_comb begin
    capturing  = (state_q == S_ARMED) || (state_q == S_TRIG);
    // ARM and ABORT both pre-empt the sample presented in the same cycle.
    wr_en      = bus.SAMPLE_EN && capturing && !bus.ABORT && !bus.ARM;
    wr_ptr_nxt = wr_ptr + 1'b1;
    at_last    = (wr_ptr == LAST_ADDR);
    is_trig    = wr_en && (state_q == S_ARMED) && bus.TRIG;
    finish     = (is_trig && (post_lat == '0)) ||
                 (wr_en && (state_q == S_TRIG) && (post_cnt == ADDR_W'(1)));
    start_nxt  = (wrapped_q || at_last) ? wr_ptr_nxt : '0;
    rd_phys    = start_q + bus.rd_addr;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wr_ptr    <= '0;
      wrapped_q <= 1'b0;
      post_lat  <= '0;
      post_cnt  <= '0;
      trig_q    <= '0;
      start_q   <= '0;
    end else if (bus.ABORT) begin
      state_q <= S_IDLE;
    end else if (bus.ARM) begin
      state_q   <= S_ARMED;
      wr_ptr    <= '0;
      wrapped_q <= 1'b0;
      post_lat  <= bus.post_count;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr_nxt;
      if (at_last) wrapped_q <= 1'b1;
      if (is_trig) begin
        trig_q   <= wr_ptr;
        post_cnt <= post_lat;
      end
      if (state_q == S_TRIG) post_cnt <= post_cnt - 1'b1;
      if (finish) begin
        state_q <= S_DONE;
        start_q <= start_nxt;
      end else if (is_trig) begin
        state_q <= S_TRIG;
      end
    end
  end

  bram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.sample_in),
    .re    (bus.RD_EN),
    .raddr (rd_phys),
    .rdata (bus.data_out)
  );

  assign bus.state      = state_q;
  assign bus.DONE       = (state_q == S_DONE);
  assign bus.wrapped    = wrapped_q;
  assign bus.trig_addr  = trig_q;
  assign bus.start_addr = start_q;
endmodule

// File: tb/tb_capture_bram.sv
// Directed bench for capture_bram at DATA_W=8, ADDR_W=4 (depth 16).
module tb_capture_bram;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  capture_bram_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  capture_bram #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.ARM       = 1'b0;
    bus.ABORT     = 1'b0;
    bus.SAMPLE_EN = 1'b0;
    bus.TRIG      = 1'b0;
    bus.RD_EN     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 16'(bus.state), 16'd0);
    chk({tag, "_done"}, 16'(bus.DONE), 16'd0);
    chk({tag, "_wrapped"}, 16'(bus.wrapped), 16'd0);
    chk({tag, "_trig_addr"}, 16'(bus.trig_addr), 16'd0);
    chk({tag, "_start_addr"}, 16'(bus.start_addr), 16'd0);
    chk({tag, "_data_out"}, 16'(bus.data_out), 16'd0);
  endtask

  initial begin
    quiet();
    bus.sample_in  = '0;
    bus.post_count = '0;
    bus.rd_addr    = '0;
    rst = 1'b1;
    #1;
    check_reset_outputs("por");
    #11;
    rst = 1'b0;

    // Basic capture: trigger on 0x05, three post samples, no wrap.
    bus.post_count = 4'd3;
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    chk("t1_armed", 16'(bus.state), 16'd1);
    for (int i = 0; i < 10; i++) begin
      bus.sample_in = 8'(i);
      bus.TRIG      = (i == 5);
      bus.SAMPLE_EN = 1'b1;
      step();
      if (i == 5) begin
        chk("t1_trig_state", 16'(bus.state), 16'd2);
        chk("t1_trig_addr", 16'(bus.trig_addr), 16'd5);
      end
      if (i == 7) chk("t1_not_done_yet", 16'(bus.state), 16'd2);
      if (i == 8) chk("t1_done_after_08", 16'(bus.DONE), 16'd1);
    end
    quiet();
    chk("t1_done_hold", 16'(bus.state), 16'd3);
    chk("t1_wrapped", 16'(bus.wrapped), 16'd0);
    chk("t1_start", 16'(bus.start_addr), 16'd0);
    bus.RD_EN = 1'b1;
    bus.rd_addr = 4'd5;
    step();
    chk("t1_rd5", 16'(bus.data_out), 16'h05);
    bus.rd_addr = 4'd8;
    step();
    chk("t1_rd8", 16'(bus.data_out), 16'h08);
    quiet();

    // Wrapping capture: 20 pre samples, trigger on 0x24, four post samples.
    bus.post_count = 4'd4;
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    for (int i = 0; i < 25; i++) begin
      bus.sample_in = 8'(8'h10 + i);
      bus.TRIG      = (i == 20);
      bus.SAMPLE_EN = 1'b1;
      step();
      if (i == 23) chk("t2_not_done_yet", 16'(bus.state), 16'd2);
    end
    quiet();
    chk("t2_done", 16'(bus.state), 16'd3);
    chk("t2_wrapped", 16'(bus.wrapped), 16'd1);
    chk("t2_trig_addr", 16'(bus.trig_addr), 16'd4);
    chk("t2_start", 16'(bus.start_addr), 16'd9);
    bus.RD_EN = 1'b1;
    bus.rd_addr = 4'd0;
    step();
    chk("t2_rd0", 16'(bus.data_out), 16'h19);
    bus.rd_addr = 4'd15;
    step();
    chk("t2_rd15", 16'(bus.data_out), 16'h28);

    // Read enable low: output holds while the address moves.
    bus.RD_EN = 1'b0;
    bus.rd_addr = 4'd3;
    step();
    chk("hold_1", 16'(bus.data_out), 16'h28);
    bus.rd_addr = 4'd7;
    step();
    chk("hold_2", 16'(bus.data_out), 16'h28);

    // post_count=0: trigger on first sample goes straight to DONE.
    bus.post_count = 4'd0;
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    bus.sample_in = 8'hAA;
    bus.TRIG = 1'b1;
    bus.SAMPLE_EN = 1'b1;
    step();
    quiet();
    chk("t3_done", 16'(bus.state), 16'd3);
    chk("t3_trig_addr", 16'(bus.trig_addr), 16'd0);
    chk("t3_start", 16'(bus.start_addr), 16'd0);
    bus.RD_EN = 1'b1;
    bus.rd_addr = 4'd0;
    step();
    chk("t3_rd0", 16'(bus.data_out), 16'hAA);
    quiet();

    // Read-first collision at physical address 0.
    bus.post_count = 4'd2;
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    bus.sample_in = 8'h77;
    bus.SAMPLE_EN = 1'b1;
    bus.RD_EN = 1'b1;
    bus.rd_addr = 4'd0;
    step();
    chk("collide_old", 16'(bus.data_out), 16'hAA);
    bus.SAMPLE_EN = 1'b0;
    step();
    chk("collide_new", 16'(bus.data_out), 16'h77);
    bus.RD_EN = 1'b0;
    bus.sample_in = 8'h31;
    bus.TRIG = 1'b1;
    bus.SAMPLE_EN = 1'b1;
    step();
    chk("t4_trig_state", 16'(bus.state), 16'd2);
    chk("t4_trig_addr", 16'(bus.trig_addr), 16'd1);

    // ABORT with ARM in TRIGGERED: back to IDLE, later samples not stored.
    bus.TRIG = 1'b0;
    bus.ABORT = 1'b1;
    bus.ARM = 1'b1;
    bus.sample_in = 8'h99;
    step();
    bus.ABORT = 1'b0;
    bus.ARM = 1'b0;
    chk("t4_abort_idle", 16'(bus.state), 16'd0);
    chk("t4_abort_trig_addr", 16'(bus.trig_addr), 16'd1);
    chk("t4_abort_start", 16'(bus.start_addr), 16'd0);
    bus.sample_in = 8'hEE;
    step();
    step();
    step();
    chk("t4_idle_stays", 16'(bus.state), 16'd0);
    bus.SAMPLE_EN = 1'b0;
    bus.RD_EN = 1'b1;
    bus.rd_addr = 4'd2;
    step();
    chk("t4_rd2_unchanged", 16'(bus.data_out), 16'h22);
    bus.rd_addr = 4'd1;
    step();
    chk("t4_rd1_unchanged", 16'(bus.data_out), 16'h31);
    quiet();

    // Asynchronous reset between edges while TRIGGERED.
    bus.post_count = 4'd3;
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    bus.SAMPLE_EN = 1'b1;
    bus.sample_in = 8'h40;
    step();
    bus.sample_in = 8'h41;
    bus.TRIG = 1'b1;
    step();
    bus.TRIG = 1'b0;
    bus.sample_in = 8'h42;
    step();
    bus.SAMPLE_EN = 1'b0;
    chk("t5_pre_rst_state", 16'(bus.state), 16'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    #1;
    rst = 1'b0;
    bus.ARM = 1'b1;
    step();
    bus.ARM = 1'b0;
    chk("t5_first_arm", 16'(bus.state), 16'd1);
    bus.RD_EN = 1'b1;
    bus.rd_addr = 4'd0;
    step();
    chk("t5_rd0_kept", 16'(bus.data_out), 16'h40);
    bus.rd_addr = 4'd2;
    step();
    chk("t5_rd2_kept", 16'(bus.data_out), 16'h42);
    quiet();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
